// File: rtl/rtc_clk_div_bank_pkg.sv
// Shared types for the RTC clock divider bank.
// Channel operating modes and the smallest divisor that can run.
package rtc_clk_div_bank_pkg;

    typedef enum logic [1:0] {
        ChDisabled,
        ChInvalid,
        ChRun
    } ch_state_e;

    localparam int unsigned MinDiv = 2;

endpackage

// File: rtl/rtc_clk_div_chan.sv
// One divider channel: programmable period, glitch-free reload at wrap,
// registered divided clock and wrap tick.
module rtc_clk_div_chan
    import rtc_clk_div_bank_pkg::*;
#(
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned DefaultDiv = 50
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [CntWidth-1:0] div_i,
    input  logic                sync_i,
    output logic                clk_o,
    output logic                tick_o
);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] div_q;
    logic [CntWidth-1:0] wrap_val;
    logic [CntWidth-1:0] rise_val;
    logic                clk_q;
    logic                tick_q;
    logic                wrap;
    ch_state_e           state;

    assign wrap_val = div_q - CntWidth'(1);
    assign rise_val = div_q - (div_q >> 1);
    assign wrap     = (cnt_q == wrap_val);

    always_comb begin
        state = ChRun;
        if (!en_i) begin
            state = ChDisabled;
        end else if (div_q < CntWidth'(MinDiv)) begin
            state = ChInvalid;
        end
    end

    // Idle modes keep tracking div_i so an enable starts on the latest value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= CntWidth'(DefaultDiv);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            case (state)
                ChRun: begin
                    clk_q  <= (cnt_q >= rise_val);
                    tick_q <= wrap;
                    if (wrap) begin
                        cnt_q <= '0;
                        div_q <= div_i;
                    end else if (sync_i) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    cnt_q  <= '0;
                    div_q  <= div_i;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/rtc_clk_div_bank.sv
// Bank of independent RTC divider channels sharing one phase-sync restart.
// Each channel produces a divided clock level and a wrap tick.
module rtc_clk_div_bank
    import rtc_clk_div_bank_pkg::*;
#(
    parameter int unsigned NumCh      = 2,
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned DefaultDiv = 50
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumCh-1:0]                en_i,
    input  logic [NumCh-1:0][CntWidth-1:0]  div_i,
    input  logic                            sync_i,
    output logic [NumCh-1:0]                clk_o,
    output logic [NumCh-1:0]                tick_o
);

    for (genvar g = 0; g < NumCh; g++) begin : g_chan
        rtc_clk_div_chan #(
            .CntWidth  (CntWidth),
            .DefaultDiv(DefaultDiv)
        ) u_chan (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .en_i  (en_i[g]),
            .div_i (div_i[g]),
            .sync_i(sync_i),
            .clk_o (clk_o[g]),
            .tick_o(tick_o[g])
        );
    end

endmodule

// File: tb/tb_rtc_clk_div_bank.sv
// Scoreboard bench for rtc_clk_div_bank: a period/phase reference model
// queues expected outputs per cycle; a monitor compares on the falling edge.
module tb_rtc_clk_div_bank;

    localparam int NCH = 2;
    localparam int W   = 16;
    localparam int DEF = 50;

    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tick;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [NCH-1:0]         en;
    logic [NCH-1:0][W-1:0]  div;
    logic                   sync;
    logic [NCH-1:0]         clk_o;
    logic [NCH-1:0]         tick_o;

    exp_t q[$];
    int   n_checks;
    int   n_fail;

    // Reference: position within the current period and the active period length.
    int   pos[NCH];
    int   per[NCH];

    rtc_clk_div_bank #(
        .NumCh     (NCH),
        .CntWidth  (W),
        .DefaultDiv(DEF)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .en_i  (en),
        .div_i (div),
        .sync_i(sync),
        .clk_o (clk_o),
        .tick_o(tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0d required %0d",
                     name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            pos[c] = 0;
            per[c] = DEF;
        end
    endtask

    // Called at the active edge with the inputs the DUT samples there.
    task automatic model_step();
        exp_t e;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!en[c] || per[c] < 2) begin
                pos[c] = 0;
                per[c] = int'(div[c]);
            end else begin
                // low for ceil(per/2) cycles, then high
                e.clk[c]  = (pos[c] >= (per[c] + 1) / 2);
                e.tick[c] = (pos[c] == per[c] - 1);
                if (pos[c] == per[c] - 1) begin
                    pos[c] = 0;
                    per[c] = int'(div[c]);
                end else if (sync) begin
                    pos[c] = 0;
                end else begin
                    pos[c] = pos[c] + 1;
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            sync = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_clk", int'(clk_o), 0);
        check("rst_tick", int'(tick_o), 0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("clk_o[%0d]", c), int'(clk_o[c]), int'(e.clk[c]));
                    check($sformatf("tick_o[%0d]", c), int'(tick_o[c]), int'(e.tick[c]));
                end
            end
        end
    end

    initial begin : stim
        int guard;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = '1;
        div[0]   = W'(50);
        div[1]   = W'(50);
        sync     = 1'b0;
        model_reset();
        #3;
        check("init_clk", int'(clk_o), 0);
        check("init_tick", int'(tick_o), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // div 50 from reset: 25 low / 25 high, tick every 50
        cyc(160);

        // reprogram to 10 mid-period; old period must complete
        do_reset();
        cyc(10);
        div[0] = W'(10);
        cyc(100);

        // odd divisor
        div[0] = W'(5);
        cyc(40);

        // disable mid-period, then re-enable
        div[0] = W'(50);
        cyc(10);
        guard = 0;
        while (pos[0] != 30 && guard < 200) begin
            cyc(1);
            guard++;
        end
        check("reach_cnt30", int'(guard < 200), 1);
        en[0] = 1'b0;
        cyc(5);
        en[0] = 1'b1;
        cyc(60);

        // two ratios, sync mid-period then sync on a wrap cycle
        div[0] = W'(4);
        div[1] = W'(6);
        cyc(60);
        cyc(3);
        sync = 1'b1;
        cyc(30);
        guard = 0;
        while (pos[0] != 3 && guard < 20) begin
            cyc(1);
            guard++;
        end
        check("reach_wrap", int'(guard < 20), 1);
        sync = 1'b1;
        cyc(30);

        // illegal divisors hold the channel idle until a legal one loads
        div[0] = W'(0);
        cyc(15);
        div[0] = W'(1);
        cyc(10);
        div[0] = W'(3);
        cyc(15);

        // asynchronous reset mid-run
        do_reset();
        cyc(20);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if ($urandom_range(0, 14) == 0)
                div[$urandom_range(0, NCH - 1)] = W'($urandom_range(0, 12));
            if ($urandom_range(0, 24) == 0) sync = 1'b1;
            if ($urandom_range(0, 999) == 0) do_reset();
            cyc(1);
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
